// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//
// Two requesters share one combinational logic unit (AND / OR / XOR / NOT a)
// and one result register. A round-robin arbiter picks at most one requester
// per cycle; the winner's operands pass through the logic unit and are
// captured in the result register on the same rising edge.
//
// Handshake: every channel uses strict valid/ready semantics. A beat
// transfers on a rising edge where valid and ready are both high. Valid may
// be dropped at any time before that edge. Ready never depends on payload.
//
// Ports
//   clk_in          single clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   req_valid_in    [1:0] per-requester request valid (bit i = requester i)
//   req_ready_out   [1:0] per-requester accept, one-hot or zero
//   a0_in, b0_in    requester 0 operands
//   op0_in          requester 0 opcode (00 AND, 01 OR, 10 XOR, 11 NOT a)
//   a1_in, b1_in    requester 1 operands
//   op1_in          requester 1 opcode
//   res_valid_out   result register holds a valid result
//   res_ready_in    consumer accepts the result
//   y_out           registered result
//   res_id_out      requester that owns y_out
//   zr_out          y_out is all zeros
//   dbg_state_out   result FSM state (0 EMPTY, 1 FULL)
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [1:0]       req_valid_in,
  output logic [1:0]       req_ready_out,
  input  logic [WIDTH-1:0] a0_in,
  input  logic [WIDTH-1:0] b0_in,
  input  logic [1:0]       op0_in,
  input  logic [WIDTH-1:0] a1_in,
  input  logic [WIDTH-1:0] b1_in,
  input  logic [1:0]       op1_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [WIDTH-1:0] y_out,
  output logic             res_id_out,
  output logic             zr_out,
  output logic             dbg_state_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] y_q;
  logic             id_q;

  logic             slot_free;
  logic             transfer;
  logic             win_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] alu_y;

  // Arbiter. The slot is free when the register is empty or is being drained
  // this cycle. Ready is also held low while reset is asserted so nothing can
  // look accepted in a cycle where the registers are being cleared.
  always_comb begin
    req_ready_out = 2'b00;
    slot_free     = (state_q == EMPTY) || res_ready_in;
    if (rst_n_in && slot_free) begin
      case (req_valid_in)
        2'b01:   req_ready_out = 2'b01;
        2'b10:   req_ready_out = 2'b10;
        // last_grant marks the previous winner; the other one goes now.
        2'b11:   req_ready_out = last_grant_q ? 2'b01 : 2'b10;
        default: req_ready_out = 2'b00;
      endcase
    end
  end

  // Ready is only ever raised for a valid requester, so any ready bit is a
  // transfer and bit 1 identifies the winner.
  assign transfer = |req_ready_out;
  assign win_id   = req_ready_out[1];

  // Operand mux driven by the grant only; the loser's operands (possibly X)
  // are never selected.
  always_comb begin
    op_a   = a0_in;
    op_b   = b0_in;
    op_sel = op0_in;
    if (win_id) begin
      op_a   = a1_in;
      op_b   = b1_in;
      op_sel = op1_in;
    end
  end

  // Shared logic unit.
  always_comb begin
    alu_y = '0;
    case (op_sel)
      2'b00:   alu_y = op_a & op_b;
      2'b01:   alu_y = op_a | op_b;
      2'b10:   alu_y = op_a ^ op_b;
      default: alu_y = ~op_a;
    endcase
  end

  // Result FSM next state. A transfer always leaves the register FULL,
  // which covers both the fill and the drain-and-refill (no bubble) cases.
  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && res_ready_in) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      y_q          <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        y_q          <= alu_y;
        id_q         <= win_id;
        last_grant_q <= win_id;
      end
    end
  end

  assign res_valid_out = (state_q == FULL);
  assign y_out         = y_q;
  assign res_id_out    = id_q;
  // Zero flag comes from the registered value so it always matches y_out.
  assign zr_out        = ~|y_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int WIDTH = 16;

  logic             clk_in;
  logic             rst_n_in;
  logic [1:0]       req_valid_in;
  logic [1:0]       req_ready_out;
  logic [WIDTH-1:0] a0_in, b0_in, a1_in, b1_in;
  logic [1:0]       op0_in, op1_in;
  logic             res_valid_out;
  logic             res_ready_in;
  logic [WIDTH-1:0] y_out;
  logic             res_id_out;
  logic             zr_out;
  logic             dbg_state_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .a0_in         (a0_in),
    .b0_in         (b0_in),
    .op0_in        (op0_in),
    .a1_in         (a1_in),
    .b1_in         (b1_in),
    .op1_in        (op1_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .y_out         (y_out),
    .res_id_out    (res_id_out),
    .zr_out        (zr_out),
    .dbg_state_out (dbg_state_out)
  );

  // Clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Driver tasks
  task automatic apply_reset();
    rst_n_in     = 1'b0;
    req_valid_in = 2'b00;
    res_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in     = 1'b0;
    req_valid_in = 2'b11;
    res_ready_in = 1'b1;
    a0_in = 16'h1234; b0_in = 16'h5678; op0_in = 2'b00;
    a1_in = 16'h9abc; b1_in = 16'hdef0; op1_in = 2'b01;
    #3;
    n_checks++;
    if (res_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid_out); end
    n_checks++;
    if (y_out !== 16'h0000) begin n_fail++; $display("FAIL reset_y: got %h expected 0000", y_out); end
    n_checks++;
    if (zr_out !== 1'b1) begin n_fail++; $display("FAIL reset_zr: got %b expected 1", zr_out); end
    n_checks++;
    if (res_id_out !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b expected 0", res_id_out); end
    n_checks++;
    if (req_ready_out !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready_out); end
    step();
    n_checks++;
    if (res_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_no_transfer: got valid %b expected 0", res_valid_out); end
    n_checks++;
    if (dbg_state_out !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0", dbg_state_out); end
    apply_reset();
  endtask

  task automatic test_single_op();
    apply_reset();
    req_valid_in = 2'b01;
    a0_in = 16'h00F0; b0_in = 16'h0F00; op0_in = 2'b01;
    res_ready_in = 1'b1;
    #1;
    n_checks++;
    if (req_ready_out !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready_out); end
    step();
    req_valid_in = 2'b00;
    n_checks++;
    if (y_out !== 16'h0FF0) begin n_fail++; $display("FAIL single_y: got %h expected 0ff0", y_out); end
    n_checks++;
    if (res_id_out !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b expected 0", res_id_out); end
    n_checks++;
    if (zr_out !== 1'b0) begin n_fail++; $display("FAIL single_zr: got %b expected 0", zr_out); end
    n_checks++;
    if (res_valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", res_valid_out); end
  endtask

  // Contention then backpressure, continuing from the same arbiter history.
  task automatic test_contention_backpressure();
    logic [1:0] exp_rdy;
    logic       exp_id;
    logic [WIDTH-1:0] y_hold;
    apply_reset();
    // requester 0: 0xFF00 & 0x0FF0 = 0x0F00; requester 1: 0x1234 ^ 0x00FF = 0x12CB
    a0_in = 16'hFF00; b0_in = 16'h0FF0; op0_in = 2'b00;
    a1_in = 16'h1234; b1_in = 16'h00FF; op1_in = 2'b10;
    req_valid_in = 2'b11;
    res_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id  = i[0];
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_q.push_back(exp_id ? 16'h12CB : 16'h0F00);
      #1;
      n_checks++;
      if (req_ready_out !== exp_rdy) begin n_fail++; $display("FAIL contend_ready[%0d]: got %b expected %b", i, req_ready_out, exp_rdy); end
      step();
      n_checks++;
      if (res_id_out !== exp_id) begin n_fail++; $display("FAIL contend_id[%0d]: got %b expected %b", i, res_id_out, exp_id); end
      n_checks++;
      if (res_valid_out !== 1'b1) begin n_fail++; $display("FAIL contend_valid[%0d]: got %b expected 1", i, res_valid_out); end
      n_checks++;
      if (y_out !== exp_q[0]) begin n_fail++; $display("FAIL contend_y[%0d]: got %h expected %h", i, y_out, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    // Backpressure: requester 1 owns the held result.
    res_ready_in = 1'b0;
    y_hold = 16'h12CB;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (req_ready_out !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready_out); end
      step();
      n_checks++;
      if (y_out !== y_hold || res_id_out !== 1'b1 || res_valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got y=%h id=%b v=%b expected y=%h id=1 v=1", i, y_out, res_id_out, res_valid_out, y_hold);
      end
    end
    res_ready_in = 1'b1;
    #1;
    n_checks++;
    if (req_ready_out !== 2'b01) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 01", req_ready_out); end
    step();
    n_checks++;
    if (y_out !== 16'h0F00 || res_id_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_result: got y=%h id=%b expected y=0f00 id=0", y_out, res_id_out);
    end
    req_valid_in = 2'b00;
  endtask

  task automatic test_ops();
    logic [WIDTH-1:0] exp_tab [4];
    exp_tab[0] = 16'hAAAA;
    exp_tab[1] = 16'hFFFF;
    exp_tab[2] = 16'h5555;
    exp_tab[3] = 16'h5555;
    apply_reset();
    a1_in = 'x; b1_in = 'x; op1_in = 'x;
    a0_in = 16'hAAAA; b0_in = 16'hFFFF;
    req_valid_in = 2'b01;
    res_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op0_in = 2'(i);
      step();
      n_checks++;
      if (y_out !== exp_tab[i]) begin n_fail++; $display("FAIL op_%0d: got %h expected %h", i, y_out, exp_tab[i]); end
    end
    a0_in = 16'h3C3C; b0_in = 16'h3C3C; op0_in = 2'b10;
    step();
    n_checks++;
    if (y_out !== 16'h0000 || zr_out !== 1'b1) begin
      n_fail++;
      $display("FAIL op_xor_equal: got y=%h zr=%b expected y=0000 zr=1", y_out, zr_out);
    end
    req_valid_in = 2'b00;
    a1_in = '0; b1_in = '0; op1_in = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a1_in = 16'h00FF; b1_in = 16'h0000; op1_in = 2'b11;
    req_valid_in = 2'b10;
    res_ready_in = 1'b0;
    step();
    n_checks++;
    if (y_out !== 16'hFF00 || res_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fill: got y=%h v=%b expected y=ff00 v=1", y_out, res_valid_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if (res_valid_out !== 1'b0 || y_out !== 16'h0000 || zr_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_async_clear: got v=%b y=%h zr=%b expected v=0 y=0000 zr=1", res_valid_out, y_out, zr_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    a1_in = 16'h0F0F; b1_in = 16'hF000; op1_in = 2'b01;
    res_ready_in = 1'b1;
    #1;
    n_checks++;
    if (req_ready_out !== 2'b10) begin n_fail++; $display("FAIL mid_after_ready: got %b expected 10", req_ready_out); end
    step();
    n_checks++;
    if (y_out !== 16'hFF0F || res_id_out !== 1'b1 || res_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_result: got y=%h id=%b v=%b expected y=ff0f id=1 v=1", y_out, res_id_out, res_valid_out);
    end
    req_valid_in = 2'b00;
  endtask

  task automatic test_drain();
    apply_reset();
    a0_in = 16'hFFFF; b0_in = 16'h1234; op0_in = 2'b00;
    req_valid_in = 2'b01;
    res_ready_in = 1'b1;
    step();
    req_valid_in = 2'b00;
    n_checks++;
    if (res_valid_out !== 1'b1 || y_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL drain_fill: got v=%b y=%h expected v=1 y=1234", res_valid_out, y_out);
    end
    step();
    n_checks++;
    if (res_valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", res_valid_out); end
    n_checks++;
    if (y_out !== 16'h1234) begin n_fail++; $display("FAIL drain_hold_y: got %h expected 1234", y_out); end
  endtask

  initial begin
    rst_n_in     = 1'b0;
    req_valid_in = 2'b00;
    res_ready_in = 1'b0;
    a0_in = '0; b0_in = '0; op0_in = '0;
    a1_in = '0; b1_in = '0; op1_in = '0;
    #2;
    test_reset();
    test_single_op();
    test_contention_backpressure();
    test_ops();
    test_reset_mid();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule
